// File: rtl/dsram_responder.sv
// Data-side SRAM responder: word RAM with byte-lane writes plus an MMIO window
// (LED, switches, timer, scratch, compare/IRQ). One-cycle registered read.
module dsram_lane_merge (
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  input  logic       we_i,
  output logic [7:0] mrg_o
);
  assign mrg_o = we_i ? new_i : old_i;
endmodule

module dsram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic        timer_irq
);
  localparam int NUM_LANES = 4;

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH = 16'h000C;
  localparam logic [15:0] OFF_COMPARE = 16'h0010;

  logic                    mmio_hit;
  logic [15:0]             off;
  logic [ADDR_W-1:0]       idx;
  logic                    wr;
  logic                    wr_led, wr_timer, wr_scratch, wr_cmp;
  logic [31:0]             ram_rd, mmio_rd;
  logic [NUM_LANES-1:0][7:0] merged;

  logic [NUM_LANES-1:0][7:0] mem [2**ADDR_W];

  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign off      = data_sram_addr[15:0];
  assign idx      = data_sram_addr[ADDR_W+1:2];
  assign wr       = data_sram_en && (data_sram_wen != 4'b0000);

  // Byte-granular addresses alias onto the word; bits above the RAM index alias too.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, data_sram_addr};

  assign wr_led     = wr && mmio_hit && (off == OFF_LED);
  assign wr_timer   = wr && mmio_hit && (off == OFF_TIMER);
  assign wr_scratch = wr && mmio_hit && (off == OFF_SCRATCH);
  assign wr_cmp     = wr && mmio_hit && (off == OFF_COMPARE);

  always_comb begin
    mmio_rd = 32'h0;
    unique case (off)
      OFF_LED:     mmio_rd = {16'h0, led_q};
      OFF_SWITCH:  mmio_rd = {24'h0, switch_in};
      OFF_TIMER:   mmio_rd = timer_q;
      OFF_SCRATCH: mmio_rd = scratch_q;
      OFF_COMPARE: mmio_rd = cmp_q;
      default:     mmio_rd = 32'h0;
    endcase
  end

  // Only one MMIO target per cycle, so merge the write over its current read value.
  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    dsram_lane_merge u_merge (
      .old_i (mmio_rd[8*b +: 8]),
      .new_i (data_sram_wdata[8*b +: 8]),
      .we_i  (data_sram_wen[b]),
      .mrg_o (merged[b])
    );
  end

  always_ff @(posedge clk) begin
    if (wr && !mmio_hit) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (data_sram_wen[b]) mem[idx][b] <= data_sram_wdata[8*b +: 8];
    end
  end

  assign ram_rd = mem[idx];

  always_comb begin
    led_d     = wr_led     ? merged[1:0] : led_q;
    scratch_d = wr_scratch ? merged      : scratch_q;
    cmp_d     = wr_cmp     ? merged      : cmp_q;
    timer_d   = wr_timer   ? merged      : timer_q + 32'd1;
    // Match uses this cycle's TIMER/COMPARE; a COMPARE write overrides the set.
    irq_d     = wr_cmp ? 1'b0 : (irq_q || (timer_q == cmp_q));
    rdata_d   = data_sram_en ? (mmio_hit ? mmio_rd : ram_rd) : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= 16'h0;
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
      cmp_q     <= 32'hFFFF_FFFF;
      irq_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      cmp_q     <= cmp_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led_out         = led_q;
  assign timer_irq       = irq_q;
endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: RAM lanes, read-during-write, MMIO, timer/IRQ, reset.
module tb_dsram_responder;
  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        irq;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] MB = 32'h1FAF_0000;

  dsram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch_in       (sw),
    .led_out         (led),
    .timer_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw = 8'h00;
    drv(1'b0, 4'h0, 32'h0, 32'h0);
    step(); step();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    // RAM full-word write then read
    drv(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344); step();
    drv(1'b1, 4'h0, 32'h0000_0100, 32'h0);         step();
    chk("ram_word", rdata, 32'h1122_3344);

    // Byte lanes
    drv(1'b1, 4'b0010, 32'h0000_0100, 32'hAABB_CCDD); step();
    drv(1'b1, 4'b0000, 32'h0000_0100, 32'h0);         step();
    chk("ram_lane1", rdata, 32'h1122_CC44);
    drv(1'b1, 4'b1100, 32'h0000_0100, 32'hEEFF_0000); step();
    drv(1'b1, 4'b0000, 32'h0000_0102, 32'h0);         step();
    chk("ram_lane23", rdata, 32'hEEFF_CC44);

    // Read-during-write returns old data; next read sees the write
    drv(1'b1, 4'hF, 32'h0000_0100, 32'h0); step();
    chk("rdw_old", rdata, 32'hEEFF_CC44);
    drv(1'b1, 4'h0, 32'h0000_0100, 32'h0); step();
    chk("rdw_new", rdata, 32'h0);

    // LED / SWITCH / unmapped
    drv(1'b1, 4'hF, MB, 32'hDEAD_BEEF); step();
    chk("led_out", {16'h0, led}, 32'h0000_BEEF);
    drv(1'b1, 4'h0, MB, 32'h0); step();
    chk("led_read", rdata, 32'h0000_BEEF);
    drv(1'b1, 4'b0010, MB, 32'h0000_1200); step();
    chk("led_lane", {16'h0, led}, 32'h0000_12EF);
    sw = 8'h5A;
    drv(1'b1, 4'h0, MB | 32'h4, 32'h0); step();
    chk("switch_read", rdata, 32'h0000_005A);
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 4'h0, 32'h0000_0100, 32'h0); step();
      chk("en0_hold", rdata, 32'h0000_005A);
    end
    drv(1'b1, 4'hF, MB | 32'h40, 32'hFFFF_FFFF); step();
    drv(1'b1, 4'h0, MB | 32'h40, 32'h0);         step();
    chk("unmapped_read", rdata, 32'h0);
    drv(1'b1, 4'b0101, MB | 32'hC, 32'h1234_5678); step();
    drv(1'b1, 4'b0000, MB | 32'hC, 32'h0);         step();
    chk("scratch_lane", rdata, 32'h0034_0078);

    // Timer read of current value, wrap, and wrap-triggered match with COMPARE reset value
    drv(1'b1, 4'hF, MB | 32'h8, 32'hFFFF_FFFE); step();
    drv(1'b1, 4'h0, MB | 32'h8, 32'h0); step();
    chk("timer_rd0", rdata, 32'hFFFF_FFFE);
    step();
    chk("timer_rd1", rdata, 32'hFFFF_FFFF);
    chk("irq_wrapmatch", {31'h0, irq}, 32'h1);
    step();
    chk("timer_wrap", rdata, 32'h0);

    // COMPARE write clears; IRQ rises 6 cycles after the TIMER write edge
    drv(1'b1, 4'hF, MB | 32'h10, 32'h5); step();
    chk("irq_clear", {31'h0, irq}, 32'h0);
    drv(1'b1, 4'hF, MB | 32'h8, 32'h0); step();
    drv(1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("irq_early", {31'h0, irq}, 32'h0);
    end
    step();
    chk("irq_rise", {31'h0, irq}, 32'h1);
    step(); step();
    chk("irq_sticky", {31'h0, irq}, 32'h1);

    // Match and COMPARE write in the same cycle: clear wins
    drv(1'b1, 4'hF, MB | 32'h10, 32'h20); step();
    chk("irq_clear2", {31'h0, irq}, 32'h0);
    drv(1'b1, 4'hF, MB | 32'h8, 32'h1E); step();
    drv(1'b0, 4'h0, 32'h0, 32'h0); step(); step();
    drv(1'b1, 4'hF, MB | 32'h10, 32'h20); step();
    chk("clear_wins", {31'h0, irq}, 32'h0);
    drv(1'b0, 4'h0, 32'h0, 32'h0); step();
    chk("no_late_set", {31'h0, irq}, 32'h0);

    // Mid-run reset
    drv(1'b1, 4'hF, MB | 32'h10, 32'h1234); step();
    drv(1'b1, 4'b0011, MB, 32'h0000_FFFF); step();
    drv(1'b1, 4'hF, MB | 32'h8, 32'h1234); step();
    drv(1'b1, 4'h0, MB | 32'hC, 32'h0); step();
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    chk("pre_rst_led", {16'h0, led}, 32'h0000_FFFF);
    chk("pre_rst_rdata", rdata, 32'h0034_0078);
    rst = 1'b1;
    drv(1'b1, 4'hF, MB, 32'h0000_AAAA); step();
    rst = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    drv(1'b1, 4'h0, MB | 32'h8, 32'h0); step();
    chk("rst_timer0", rdata, 32'h0);
    drv(1'b1, 4'h0, MB | 32'h10, 32'h0); step();
    chk("rst_compare", rdata, 32'hFFFF_FFFF);
    drv(1'b1, 4'h0, MB | 32'h8, 32'h0); step();
    chk("rst_timer_cnt", rdata, 32'h2);
    chk("rst_led_discard", {16'h0, led}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dsram_responder.md
# dsram_responder

Data-side SRAM responder for the single-issue MIPS core. It sits on the far end of the `data_sram_*` bus that the MEM stage drives and answers every access with one-cycle read latency. It backs a word-organised data RAM with byte-lane writes, plus a small MMIO register window holding LEDs, switches, a free-running timer and a compare interrupt. It is the bench/FPGA counterpart of the memory stage's initiator port.

## Interface
Parameters:
- `ADDR_W`, default 12: word-index width of the RAM (2^ADDR_W words, 16 KB by default).
- `MMIO_BASE`, default 32'h1FAF_0000: base of the MMIO window; only bits [31:16] are compared.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_sram_en`  in  1  access strobe.
- `data_sram_wen`  in  4  byte write enables, bit i -> byte lane i (bits [8i+7:8i]).
- `data_sram_addr`  in  32  byte address (physical).
- `data_sram_wdata`  in  32  write data.
- `data_sram_rdata`  out  32  registered read data.
- `switch_in`  in  8  board switches, sampled on read.
- `led_out`  out  16  LED register value.
- `timer_irq`  out  1  sticky compare-match interrupt.

## Operation
- Decode: MMIO hit when `addr[31:16] == MMIO_BASE[31:16]`; otherwise RAM. `addr[1:0]` is ignored and the access is word-aligned. RAM index is `addr[ADDR_W+1:2]`. Higher bits alias.
- MMIO map (offset = `addr[15:0]`):
  - 0x00 LED: RW, bits [15:0]; upper bits read 0.
  - 0x04 SWITCH: RO, `{24'b0, switch_in}`.
  - 0x08 TIMER: RW, 32-bit.
  - 0x0C SCRATCH: RW, 32-bit.
  - 0x10 COMPARE: RW, 32-bit.
  - Any other offset reads 0; writes there are ignored.
- Writes: when `en=1` and `wen!=0`, only the enabled byte lanes of the target word/register update. This applies to RAM and to the MMIO registers. Writes to SWITCH are ignored.
- Reads: every `en=1` cycle, including write cycles, registers the old (pre-write) value of the target into `data_sram_rdata`.
  - When `en=0`, `rdata` holds its previous value.
- TIMER: increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write to TIMER takes priority over the increment: the merged value is loaded, and counting resumes from it on the next cycle.
- IRQ: `timer_irq` is set on the cycle after TIMER equals COMPARE, and stays set (sticky).
  - Any write to COMPARE clears it. If a match and a COMPARE write occur in the same cycle, the clear wins.
- RAM is not reset; its contents are undefined until written.

## Timing
- Read latency is exactly 1 cycle: address in cycle N, data valid from cycle N+1 and held until the next `en` cycle.
- Write data is visible to a read issued in the next cycle (N+1 read returns the N write).
- Read-during-write to the same word in the same cycle returns the old data.
- No stall or back-pressure; every cycle can carry an access.
- Reset values:
  - `data_sram_rdata` = 0, `led_out` = 0, `timer_irq` = 0.
  - TIMER = 0, SCRATCH = 0, COMPARE = 32'hFFFF_FFFF.
- Reset asserted mid-operation: all registers above return to their reset values on that edge. A write presented in the reset cycle is discarded for MMIO; the RAM write may occur and is don't-care.
- TIMER reads: a read in cycle N returns the value TIMER held in cycle N, not N+1.
- COMPARE match check uses the current-cycle TIMER, before increment or load.

## Test plan
- Reset, then RAM write 0x1122_3344 to addr 0x0000_0100 with `wen=1111`; read 0x100 next cycle -> `rdata`=0x1122_3344 one cycle after the read.
- Byte lanes: write `wen=0010`, `wdata=0xAABB_CCDD` to 0x100, then read -> 0x1122_CC44. A `wen=1100` write of 0xEEFF_0000 -> 0xEEFF_CC44.
- Read-during-write: same cycle as a write of 0x0 to 0x100 with `en=1` -> `rdata`=0xEEFF_CC44; a read on the next cycle -> 0x0. With `en=0` held for 3 cycles, `rdata` is unchanged.
- MMIO LED/SWITCH: write 0x1FAF_0000 with 0xDEAD_BEEF -> `led_out`=0xBEEF. With `switch_in`=0x5A, read 0x1FAF_0004 -> 0x0000_005A. Reading offset 0x40 -> 0.
- Timer/IRQ:
  - Write TIMER 0xFFFF_FFFE, then read twice consecutively -> 0xFFFF_FFFE, 0xFFFF_FFFF.
  - Write COMPARE = 5 and TIMER = 0 -> `timer_irq` rises exactly 6 cycles after the TIMER write edge and stays high.
  - A COMPARE write clears it on the next cycle.
- Reset mid-run: with TIMER=0x1234, LED=0xFFFF and irq=1, pulse `rst` for 1 cycle -> all outputs 0, COMPARE reads back 0xFFFF_FFFF, and TIMER counts from 0.
